// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// Instruction width, default reset PC and the buffered fetch entry layout.
package fetch_unit_pkg;

  localparam int INSTR_W = 19;
  localparam int ADDR_W  = 19;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO, DEPTH (power of 2) x WIDTH, flush beats push.
// Ports: clk_i, reset_i, flush_i, push_i/wdata_i, pop_i/rdata_o, count_o, full_o, empty_o.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign count_o = cnt_q;

  // Head reads as zero when empty so downstream sees clean outputs.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !reset_i)
      mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/gnt + in-order rvalid, instruction FIFO to decode.
// Ports: imem_* (memory side), redirect_*, instr_* (decode side); FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               ADDR_W     = 19,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int               PC_STEP    = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_stall_cnt_o,
  output logic [31:0]        redirect_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic          grant, keep_rsp;
  logic [CW:0]   credit_used;

  logic [ADDR_W-1:0] pcq_head;
  logic [CW-1:0]     pcq_cnt;
  logic              pcq_full, pcq_empty;

  logic [EW-1:0] dq_head;
  logic [CW-1:0] dq_cnt;
  logic          dq_full, dq_empty;
  logic          dq_push, dq_pop;

  // Outstanding plus buffered never exceeds FIFO_DEPTH, so responses always fit.
  assign credit_used = {1'b0, out_q} + {1'b0, dq_cnt};
  assign imem_req_o  = !reset_i && !redirect_i &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // Responses owed to a pre-redirect request are discarded.
  assign keep_rsp = imem_rvalid_i && (drop_q == '0) && !redirect_i;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(grant) - CW'(imem_rvalid_i);
    drop_d = drop_q;
    if (redirect_i) begin
      pc_d   = redirect_pc_i;
      drop_d = out_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) pc_d = pc_q + ADDR_W'(PC_STEP);
      if (imem_rvalid_i && drop_q != '0)
        drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  // Requested PCs wait here until their (non-dropped) response returns.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_pcq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (redirect_i),
    .push_i  (grant),
    .wdata_i (pc_q),
    .pop_i   (keep_rsp),
    .rdata_o (pcq_head),
    .count_o (pcq_cnt),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

  assign dq_push = keep_rsp;
  assign dq_pop  = instr_valid_o && instr_ready_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_ibuf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (redirect_i),
    .push_i  (dq_push),
    .wdata_i ({imem_rdata_i, pcq_head}),
    .pop_i   (dq_pop),
    .rdata_o (dq_head),
    .count_o (dq_cnt),
    .full_o  (dq_full),
    .empty_o (dq_empty)
  );

  assign instr_valid_o = !dq_empty;
  assign instr_o       = dq_head[EW-1:ADDR_W];
  assign instr_pc_o    = dq_head[ADDR_W-1:0];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(dq_push && dq_full && !dq_pop));
      assert (!(grant && pcq_full));
      assert (!(keep_rsp && pcq_empty));
      assert ({1'b0, pcq_cnt} <= {1'b0, out_q});
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, redir_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (!instr_valid_o && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redirect_i && redir_q != '1)     redir_q <= redir_q + 1'b1;
    end
  end

  assign fetch_stall_cnt_o = stall_q;
  assign redirect_cnt_o    = redir_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model.
// Scoreboard queue of expected {instr, pc}; monitor pops on each decode handshake.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [18:0] KEY = 19'h5A5A5;

  logic        clk = 0;
  logic        reset_i = 1;
  logic        imem_req_o;
  logic [18:0] imem_addr_o;
  logic        imem_gnt_i = 0;
  logic        imem_rvalid_i = 0;
  logic [18:0] imem_rdata_i = '0;
  logic        redirect_i = 0;
  logic [18:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 0;
  logic [18:0] instr_o;
  logic [18:0] instr_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt_o;
  logic [31:0] redirect_cnt_o;
`endif

  fetch_unit dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt_o (fetch_stall_cnt_o),
    .redirect_cnt_o    (redirect_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fetch_entry_t exp_q[$];
  logic [18:0]  pend[$];
  logic [18:0]  glog[$];
  int           gcnt = 0;
  int           glimit = 0;
  logic         hold = 0;

  // Memory: grants while under glimit, answers one cycle later unless held.
  always @(negedge clk) begin
    #1;
    imem_rvalid_i = 0;
    imem_rdata_i  = '0;
    imem_gnt_i    = 0;
    if (reset_i) begin
      pend.delete();
    end else begin
      if (!hold && pend.size() != 0) begin
        imem_rdata_i  = pend.pop_front() ^ KEY;
        imem_rvalid_i = 1;
      end
      if (imem_req_o && gcnt < glimit) begin
        imem_gnt_i = 1;
        pend.push_back(imem_addr_o);
        glog.push_back(imem_addr_o);
        gcnt++;
      end
    end
  end

  // Monitor: a handshake at the coming edge must match the scoreboard head.
  always @(negedge clk) begin
    fetch_entry_t e;
    #2;
    if (!reset_i && !redirect_i && instr_valid_o && instr_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got pc=%h instr=%h, none expected",
                 instr_pc_o, instr_o);
      end else begin
        e = exp_q.pop_front();
        if (instr_o !== e.instr || instr_pc_o !== e.pc) begin
          errors++;
          $display("FAIL instr_out: got pc=%h instr=%h expected pc=%h instr=%h",
                   instr_pc_o, instr_o, e.pc, e.instr);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic expect_pc(logic [18:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = pc ^ KEY;
    exp_q.push_back(e);
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((exp_q.size() != 0 || gcnt != glimit || pend.size() != 0) &&
           n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_%s: got %0d pending expected 0", nm, exp_q.size());
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int gb;
    cyc(2);
    #3;
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_instr_pc", instr_pc_o, 0);
    chk("rst_addr", imem_addr_o, 0);

    // Streaming: 6 fetches, first valid two cycles after the first grant.
    @(negedge clk);
    reset_i = 0;
    instr_ready_i = 1;
    gb = glog.size();
    glimit = gcnt + 6;
    for (int i = 0; i < 6; i++) expect_pc(19'(i));
    @(negedge clk); #3;
    chk("lat_valid_n1", instr_valid_o, 0);
    @(negedge clk); #3;
    chk("lat_valid_n2", instr_valid_o, 1);
    chk("lat_pc_n2", instr_pc_o, 0);
    drain("stream");
    for (int i = 0; i < 6; i++) chk("stream_addr", glog[gb+i], i);

    // Decode stalled: credit caps grants at FIFO_DEPTH.
    gb = glog.size();
    instr_ready_i = 0;
    glimit = gcnt + 10;
    for (int i = 6; i < 16; i++) expect_pc(19'(i));
    cyc(10); #3;
    chk("stall_grants", glog.size() - gb, 2);
    chk("stall_req", imem_req_o, 0);
    @(negedge clk);
    instr_ready_i = 1;
    drain("stall");

    // Redirect with PCs 4 and 5 in flight: both dropped.
    @(negedge clk);
    redirect_i = 1;
    redirect_pc_i = 19'h4;
    @(negedge clk);
    redirect_i = 0;
    hold = 1;
    glimit = gcnt + 2;
    cyc(3); #3;
    chk("two_out_req", imem_req_o, 0);
    @(negedge clk);
    redirect_i = 1;
    redirect_pc_i = 19'h40;
    #3;
    chk("redir_req", imem_req_o, 0);
    glimit = gcnt + 3;
    for (int i = 0; i < 3; i++) expect_pc(19'h40 + 19'(i));
    @(negedge clk);
    redirect_i = 0;
    hold = 0;
    drain("redir2");

    // Redirect alongside rvalid with one more outstanding: drop exactly one.
    @(negedge clk);
    hold = 1;
    glimit = gcnt + 2;
    cyc(3);
    hold = 0;
    redirect_i = 1;
    redirect_pc_i = 19'h80;
    glimit = gcnt + 2;
    expect_pc(19'h80);
    expect_pc(19'h81);
    @(negedge clk);
    redirect_i = 0;
    drain("redir_rv");

    // PC wrap at the top of the address space.
    @(negedge clk);
    redirect_i = 1;
    redirect_pc_i = 19'h7FFFE;
    gb = glog.size();
    @(negedge clk);
    redirect_i = 0;
    glimit = gcnt + 3;
    expect_pc(19'h7FFFE);
    expect_pc(19'h7FFFF);
    expect_pc(19'h00000);
    drain("wrap");
    chk("wrap_addr1", glog[gb+1], 32'h7FFFF);
    chk("wrap_addr2", glog[gb+2], 0);

    // Reset with a full buffer.
    @(negedge clk);
    instr_ready_i = 0;
    redirect_i = 1;
    redirect_pc_i = 19'h100;
    @(negedge clk);
    redirect_i = 0;
    glimit = gcnt + 2;
    cyc(4); #3;
    chk("full_valid", instr_valid_o, 1);
    chk("full_req", imem_req_o, 0);
    @(negedge clk);
    reset_i = 1;
    #3;
    chk("inrst_req", imem_req_o, 0);
    @(negedge clk);
    reset_i = 0;
    #3;
    chk("postrst_valid", instr_valid_o, 0);
    chk("postrst_addr", imem_addr_o, 0);
    chk("postrst_instr", instr_o, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("postrst_stall_cnt", fetch_stall_cnt_o, 0);
    chk("postrst_redir_cnt", redirect_cnt_o, 0);
`endif

    // Fetch resumes from the reset PC.
    @(negedge clk);
    instr_ready_i = 1;
    glimit = gcnt + 2;
    expect_pc(19'h0);
    expect_pc(19'h1);
    drain("resume");

    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
